ball_flight: RTL

Delivery engine for the cricket game. It accepts a throw request and step sizes `dx`/`dy` from the AI bowler and moves the ball across the pitch once per frame tick. It opens a timed swing window at the batting crease and resolves the delivery as a hit with runs, a dot ball, a wide, or an out. It sits between the AI bowler and the scoreboard/VGA drawing logic.

---
 rtl/ball_pkg.sv | 43 ++++
 rtl/ball_flight_stepper.sv | 36 +++
 rtl/ball_flight.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the ball_flight delivery engine.
//   - state_e   : delivery FSM states
//   - RUNS_*    : runs awarded for a hit, by swing-window tick
//   - result_t  : packed result flags (hit, out, runs) and canned values
package ball_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_WINDOW = 2'd2,
        S_RESULT = 2'd3
    } state_e;

    // Swing-window tick counter width; SWING_WIN must fit in it.
    localparam int WIN_CNT_W = 8;

    // Earlier swings earn fewer runs; late swings hit the boundary.
    localparam logic [2:0] RUNS_0 = 3'd1;
    localparam logic [2:0] RUNS_1 = 3'd2;
    localparam logic [2:0] RUNS_2 = 3'd4;
    localparam logic [2:0] RUNS_3 = 3'd6;

    typedef struct packed {
        logic       hit;
        logic       out;
        logic [2:0] runs;
    } result_t;

    localparam result_t RES_CLEAR = '{hit: 1'b0, out: 1'b0, runs: 3'd0};
    localparam result_t RES_WIDE  = '{hit: 1'b0, out: 1'b0, runs: 3'd1};

    function automatic logic [2:0] runs_for(input logic [WIN_CNT_W-1:0] w);
        logic [2:0] r;
        case (w)
            8'd0:    r = RUNS_0;
            8'd1:    r = RUNS_1;
            8'd2:    r = RUNS_2;
            default: r = RUNS_3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ball_flight_stepper.sv
// ball_stepper: combinational next ball position for one frame tick.
//   x_i/y_i   : current position
//   dx_i/dy_i : step sizes
//   x_o       : x + dx, saturated at X_MAX
//   y_o       : y + dy, clamped at BAT_Y
//   cross_o   : the step reaches or passes the crease row
//   ovf_o     : the unsaturated x sum exceeds X_MAX
module ball_stepper
    import ball_pkg::*;
#(
    parameter logic [7:0] X_MAX = 8'd159,
    parameter logic [6:0] BAT_Y = 7'd100
) (
    input  logic [7:0] x_i,
    input  logic [6:0] y_i,
    input  logic [3:0] dx_i,
    input  logic [3:0] dy_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       cross_o,
    output logic       ovf_o
);

    logic [8:0] x_sum;
    logic [7:0] y_sum;

    // Widened sums so that overflow past the field edge is visible.
    assign x_sum   = {1'b0, x_i} + {5'd0, dx_i};
    assign y_sum   = {1'b0, y_i} + {4'd0, dy_i};

    assign ovf_o   = (x_sum > {1'b0, X_MAX});
    assign cross_o = (y_sum >= {1'b0, BAT_Y});
    assign x_o     = ovf_o   ? X_MAX : x_sum[7:0];
    assign y_o     = cross_o ? BAT_Y : y_sum[6:0];

endmodule

// File: rtl/ball_flight.sv
// ball_flight: cricket delivery engine. Accepts a throw, moves the ball one
// step per frame tick, opens a swing window at the crease and resolves the
// delivery as a hit (with runs), dot ball, out, or wide.
//   clock, reset (async, active-low), tick (frame enable)
//   throw, dx, dy      : bowler request and step sizes
//   swing              : batter swing (level)
//   ball_x, ball_y     : ball position
//   busy               : FLIGHT or WINDOW
//   done               : one-cycle pulse when a result is produced
//   hit, out, runs     : result, held until the next accepted throw
// Build option: define WIDE_CHECK_EN to end a delivery as a wide when the
// ball would pass X_MAX; otherwise x saturates and the flight continues.
// Handshake: throw is a level request, accepted only in IDLE; after the
// result the FSM waits for throw to drop before it can accept another.
module ball_flight
    import ball_pkg::*;
#(
    parameter logic [7:0] START_X   = 8'd20,
    parameter logic [6:0] START_Y   = 7'd10,
    parameter logic [6:0] BAT_Y     = 7'd100,
    parameter logic [7:0] STUMP_XL  = 8'd70,
    parameter logic [7:0] STUMP_XR  = 8'd90,
    parameter logic [7:0] X_MAX     = 8'd159,
    parameter int         SWING_WIN = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       throw,
    input  logic [3:0] dx,
    input  logic [3:0] dy,
    input  logic       swing,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       out,
    output logic [2:0] runs
);

`ifdef WIDE_CHECK_EN
    localparam bit WIDE_EN = 1'b1;
`else
    localparam bit WIDE_EN = 1'b0;
`endif

    localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(SWING_WIN - 1);

    state_e               state_q, state_d;
    logic [7:0]           x_q, x_d;
    logic [6:0]           y_q, y_d;
    logic [3:0]           dx_q, dx_d;
    logic [3:0]           dy_q, dy_d;
    logic [WIN_CNT_W-1:0] win_q, win_d;
    result_t              res_q, res_d;
    logic                 done_q, done_d;

    logic [7:0] step_x;
    logic [6:0] step_y;
    logic       step_cross;
    logic       step_ovf;
    logic       in_stumps;

    ball_stepper #(
        .X_MAX (X_MAX),
        .BAT_Y (BAT_Y)
    ) u_stepper (
        .x_i     (x_q),
        .y_i     (y_q),
        .dx_i    (dx_q),
        .dy_i    (dy_q),
        .x_o     (step_x),
        .y_o     (step_y),
        .cross_o (step_cross),
        .ovf_o   (step_ovf)
    );

    assign in_stumps = (x_q >= STUMP_XL) && (x_q <= STUMP_XR);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        win_d   = win_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (throw) begin
                    dx_d    = dx;
                    dy_d    = dy;
                    x_d     = START_X;
                    y_d     = START_Y;
                    res_d   = RES_CLEAR;
                    state_d = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (tick) begin
                    x_d = step_x;
                    y_d = step_y;
                    // A wide takes precedence over reaching the crease.
                    if (WIDE_EN && step_ovf) begin
                        res_d   = RES_WIDE;
                        done_d  = 1'b1;
                        state_d = S_RESULT;
                    end else if (step_cross) begin
                        win_d   = '0;
                        state_d = S_WINDOW;
                    end
                end
            end
            S_WINDOW: begin
                // Swing is checked first so it beats the expiring tick.
                if (swing) begin
                    res_d.hit  = 1'b1;
                    res_d.out  = 1'b0;
                    res_d.runs = runs_for(win_q);
                    done_d     = 1'b1;
                    state_d    = S_RESULT;
                end else if (tick) begin
                    if (win_q == WIN_LAST) begin
                        res_d.hit  = 1'b0;
                        res_d.out  = in_stumps;
                        res_d.runs = 3'd0;
                        done_d     = 1'b1;
                        state_d    = S_RESULT;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            S_RESULT: begin
                if (!throw) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            dx_q    <= 4'd0;
            dy_q    <= 4'd0;
            win_q   <= '0;
            res_q   <= RES_CLEAR;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            win_q   <= win_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign busy   = (state_q == S_FLIGHT) || (state_q == S_WINDOW);
    assign done   = done_q;
    assign hit    = res_q.hit;
    assign out    = res_q.out;
    assign runs   = res_q.runs;

endmodule
